// File: rtl/stack.sv
// stack: LIFO data stack with registered top-of-stack and next-on-stack taps,
// a fill count, full/empty status and sticky push/pop error flags.
module stack #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16,
  parameter int CNT_SIZE  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] in,
  input  logic                 push,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] out,
  output logic [DATA_SIZE-1:0] nos,
  output logic [CNT_SIZE-1:0]  count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(DEPTH);

  // Entry k holds the (k+1)th oldest item, so mem[count-1] always mirrors out.
  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

  logic [AW-1:0]        top_idx;
  logic [AW-1:0]        third_idx;
  logic [AW-1:0]        wr_idx;
  logic [DATA_SIZE-1:0] third_val;
  logic                 do_push;
  logic                 do_pop;
  logic                 do_repl;
  logic                 push_err;
  logic                 pop_err;

  assign empty = (count == '0);
  assign full  = (count == CNT_SIZE'(DEPTH));

  // Push+pop on an empty stack degenerates into a plain push; on a full
  // stack it is a replace and therefore not an overflow.
  assign do_push  = push & (pop ? empty : ~full);
  assign do_repl  = push & pop & ~empty;
  assign do_pop   = pop & ~push & ~empty;
  assign push_err = push & ~pop & full;
  assign pop_err  = pop & ~push & empty;

  // Low index bits wrap naturally: at count == DEPTH the low bits are zero
  // and top_idx lands on DEPTH-1, which is the top entry.
  assign top_idx   = count[AW-1:0] - AW'(1);
  assign third_idx = count[AW-1:0] - AW'(3);
  assign wr_idx    = do_repl ? top_idx : count[AW-1:0];

  // After a pop the new NOS is the entry two below the current top.
  assign third_val = (count >= CNT_SIZE'(3)) ? mem[third_idx] : '0;

  // Storage array is never reset; only written by push or replace.
  always_ff @(posedge clk) begin
    if (do_push || do_repl) begin
      mem[wr_idx] <= in;
    end
  end

  // Count, TOS/NOS taps and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      out       <= '0;
      nos       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        count <= count + CNT_SIZE'(1);
        nos   <= out;
        out   <= in;
      end else if (do_repl) begin
        out   <= in;
      end else if (do_pop) begin
        count <= count - CNT_SIZE'(1);
        out   <= nos;
        nos   <= third_val;
      end
      if (push_err) begin
        overflow <= 1'b1;
      end
      if (pop_err) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack.sv
// tb_stack: table-driven directed vectors, multi-cycle corner sequences and
// randomized traffic checked against a queue-based LIFO model.
module tb_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] out;
  logic [DW-1:0] nos;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;

  stack #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(din), .push(push), .pop(pop),
    .out(out), .nos(nos), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack.
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_apply(input bit p, input bit q, input logic [DW-1:0] d);
    if (p && !q) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(d);
    end else if (q && !p) begin
      if (mq.size() == 0) m_unf = 1;
      else void'(mq.pop_back());
    end else if (p && q) begin
      if (mq.size() == 0) mq.push_back(d);
      else mq[mq.size()-1] = d;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    logic [DW-1:0] e_out;
    logic [DW-1:0] e_nos;
    int            n;
    n     = mq.size();
    e_out = (n >= 1) ? mq[n-1] : '0;
    e_nos = (n >= 2) ? mq[n-2] : '0;
    chk({tag, ".out"},       32'(out),       32'(e_out));
    chk({tag, ".nos"},       32'(nos),       32'(e_nos));
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".empty"},     32'(empty),     32'(n == 0));
    chk({tag, ".full"},      32'(full),      32'(n == DEPTH));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // One operation: inputs change on the falling edge, outputs sampled 1 after rise.
  task automatic drive(input bit p, input bit q, input logic [DW-1:0] d);
    @(negedge clk);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    model_apply(p, q, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit            p;
    bit            q;
    logic [DW-1:0] d;
    logic [DW-1:0] e_out;
    logic [DW-1:0] e_nos;
    int            e_cnt;
    bit            e_empty;
    bit            e_full;
    bit            e_ovf;
    bit            e_unf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int pp;
    bit p;
    bit q;

    //          p  q  din      out      nos     cnt emp ful ovf unf
    tbl[0]  = '{1, 0, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 16'h0002, 16'h0002, 16'h0001, 2, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 16'h0003, 16'h0003, 16'h0002, 3, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 16'h0000, 16'h0002, 16'h0001, 2, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 16'h0007, 16'h0007, 16'h0005, 2, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 16'h0009, 16'h0009, 16'h0005, 2, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 16'h0000, 16'h0005, 16'h0000, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 1, 16'h0004, 16'h0004, 16'h0000, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 1};
    tbl[14] = '{1, 0, 16'h0011, 16'h0011, 16'h0000, 1, 0, 0, 0, 1};
    tbl[15] = '{0, 0, 16'h0000, 16'h0011, 16'h0000, 1, 0, 0, 0, 1};

    // Reset state.
    do_reset();
    #1;
    chk("rst.out",       32'(out),       32'h0);
    chk("rst.nos",       32'(nos),       32'h0);
    chk("rst.count",     32'(count),     32'h0);
    chk("rst.empty",     32'(empty),     32'h1);
    chk("rst.full",      32'(full),      32'h0);
    chk("rst.overflow",  32'(overflow),  32'h0);
    chk("rst.underflow", 32'(underflow), 32'h0);

    // Directed table: push/pop order, replace on non-empty and empty, underflow.
    foreach (tbl[i]) begin
      drive(tbl[i].p, tbl[i].q, tbl[i].d);
      chk($sformatf("tbl%0d.out", i),       32'(out),       32'(tbl[i].e_out));
      chk($sformatf("tbl%0d.nos", i),       32'(nos),       32'(tbl[i].e_nos));
      chk($sformatf("tbl%0d.count", i),     32'(count),     32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.empty", i),     32'(empty),     32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.full", i),      32'(full),      32'(tbl[i].e_full));
      chk($sformatf("tbl%0d.overflow", i),  32'(overflow),  32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d.underflow", i), 32'(underflow), 32'(tbl[i].e_unf));
    end

    // Fill to DEPTH, then push on full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, DW'(i));
      model_check($sformatf("fill%0d", i));
    end
    chk("fill.full", 32'(full), 32'h1);
    chk("fill.out",  32'(out),  32'h000f);
    drive(1, 0, 16'hAAAA);
    chk("ovf.count",    32'(count),    32'd16);
    chk("ovf.out",      32'(out),      32'h000f);
    chk("ovf.nos",      32'(nos),      32'h000e);
    chk("ovf.overflow", 32'(overflow), 32'h1);
    // Sticky overflow must not block a later pop.
    drive(0, 1, 16'h0);
    chk("ovf_pop.out",      32'(out),      32'h000e);
    chk("ovf_pop.nos",      32'(nos),      32'h000d);
    chk("ovf_pop.overflow", 32'(overflow), 32'h1);

    // Replace while full is legal and raises no overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'(16'h100 + i));
    drive(1, 1, 16'hBEEF);
    chk("repl_full.out",      32'(out),      32'hBEEF);
    chk("repl_full.nos",      32'(nos),      32'h010e);
    chk("repl_full.count",    32'(count),    32'd16);
    chk("repl_full.overflow", 32'(overflow), 32'h0);
    drive(0, 1, 16'h0);
    drive(0, 1, 16'h0);
    model_check("repl_full_pop");
    chk("repl_full_pop.out", 32'(out), 32'h010d);

    // Asynchronous reset between edges with count=5 and underflow set.
    do_reset();
    drive(0, 1, 16'h0);
    for (int i = 0; i < 5; i++) drive(1, 0, DW'(16'h20 + i));
    model_check("pre_arst");
    @(negedge clk);
    push = 1'b1;
    pop  = 1'b0;
    din  = 16'h7777;
    #1;
    rst = 1'b1;
    #1;
    chk("arst.count",     32'(count),     32'h0);
    chk("arst.out",       32'(out),       32'h0);
    chk("arst.nos",       32'(nos),       32'h0);
    chk("arst.empty",     32'(empty),     32'h1);
    chk("arst.full",      32'(full),      32'h0);
    chk("arst.overflow",  32'(overflow),  32'h0);
    chk("arst.underflow", 32'(underflow), 32'h0);
    push = 1'b0;
    #1;
    rst = 1'b0;
    model_reset();
    drive(1, 0, 16'h0055);
    model_check("post_arst");
    chk("post_arst.out", 32'(out), 32'h0055);

    // Randomized traffic in alternating fill/drain phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        model_check("rnd_rst");
      end else begin
        pp = ((i / 150) % 2 == 0) ? 75 : 25;
        p  = ($urandom_range(0, 99) < pp);
        q  = ($urandom_range(0, 99) < (100 - pp));
        drive(p, q, DW'($urandom));
        model_check("rnd");
      end
    end

    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
